// File: rtl/seq_divider64.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider64
// Description : Unsigned restoring radix-2 sequential divider. One quotient
//               bit per clock, MSB first; zero divisor short-circuits to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int c_cw = $clog2(WIDTH + 1);
  localparam logic [c_cw-1:0] c_count_init = c_cw'(WIDTH);
  localparam logic [c_cw-1:0] c_count_one  = c_cw'(1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [c_cw-1:0]  r_count;
  logic [WIDTH-1:0] r_rem;      // restored remainder, always below the divisor
  logic [WIDTH-1:0] r_shift;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  // The WIDTH+1 bit partial remainder after shifting in the next dividend bit;
  // the extra bit keeps the trial comparison exact.
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_accept;
  logic             w_last;

  // One restoring step: subtract when the trial value covers the divisor.
  // The difference is taken modulo 2^WIDTH, which is exact whenever it is used.
  always_comb begin
    w_trial      = {r_rem, r_shift[WIDTH-1]};
    w_ge         = (w_trial >= {1'b0, r_divisor});
    w_diff       = w_trial[WIDTH-1:0] - r_divisor;
    w_rem_next   = w_ge ? w_diff : w_trial[WIDTH-1:0];
    w_shift_next = {r_shift[WIDTH-2:0], w_ge};
    w_accept     = (r_state == c_st_idle) && start;
    w_last       = (r_state == c_st_run) && (r_count == c_count_one);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: RUN ends on the step that takes the counter to zero.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_next_state = (divisor == '0) ? c_st_done : c_st_run;
        end
      end
      c_st_run: begin
        if (r_count == c_count_one) begin
          w_next_state = c_st_done;
        end
      end
      c_st_done: w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // Control outputs decoded from the state.
  always_comb begin
    busy = (r_state != c_st_idle);
    done = (r_state == c_st_done);
  end

  // Datapath: operand capture, iteration, and result registers written only
  // on the transition into DONE so RUN intermediates never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_shift     <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= dividend;
      r_divisor <= divisor;
      r_rem     <= '0;
      if (divisor == '0) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end else begin
        r_count <= c_count_init;
      end
    end else if (r_state == c_st_run) begin
      r_rem   <= w_rem_next;
      r_shift <= w_shift_next;
      r_count <= r_count - c_count_one;
      if (w_last) begin
        r_quotient  <= w_shift_next;
        r_remainder <= w_rem_next;
        r_dbz       <= 1'b0;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider64.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider64
// Description : Scoreboard bench for seq_divider64 with an arithmetic
//               reference model, directed corner cases and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider64;

  localparam int W     = 64;
  localparam int NRAND = 800;
  localparam int LAT   = W;     // edges from acceptance to the DONE state

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider64 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  typedef struct {
    res_t res;
    int   due;
  } exp_t;

  exp_t sb[$];
  res_t m_last = '0;
  int   cyc = 0;
  int   free_at = 0;
  int   n_accept = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_busy, exp_done;

  // Reference: plain unsigned arithmetic, zero divisor gives all-ones quotient.
  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t x;
    if (b == '0) begin
      x.q = '1; x.r = a; x.dbz = 1'b1;
    end else begin
      x.q = a / b; x.r = a % b; x.dbz = 1'b0;
    end
    return x;
  endfunction

  // Acceptance model: a request is taken when the divider has been idle,
  // i.e. two edges after the previous DONE cycle (or any time after reset).
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && start && cyc >= free_at) begin
      e.res = ref_div(dividend, divisor);
      e.due = cyc + ((divisor == '0) ? 0 : LAT);
      sb.push_back(e);
      free_at = e.due + 2;
      n_accept++;
    end
  end

  // Monitor: busy/done against the outstanding request, results held between
  // completions must equal the most recently completed expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_busy = (sb.size() > 0);
      exp_done = exp_busy && (sb[0].due == cyc);
      if (exp_done) m_last = sb.pop_front().res;
      n_cmp++;
      if ({busy, done} !== {exp_busy, exp_done}) begin
        n_bad++;
        $display("FAIL ctrl cyc=%0d busy,done actual=%b,%b required=%b,%b",
                 cyc, busy, done, exp_busy, exp_done);
      end
      n_cmp++;
      if ({quotient, remainder, div_by_zero} !== m_last) begin
        n_bad++;
        $display("FAIL result cyc=%0d q/r/dbz actual=%h/%h/%b required=%h/%h/%b",
                 cyc, quotient, remainder, div_by_zero, m_last.q, m_last.r, m_last.dbz);
      end
    end
  end

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || cyc < free_at - 1) && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 300) begin
      n_bad++;
      $display("FAIL drain_timeout cyc=%0d pending actual=%0d required=0", cyc, sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_bad++;
      $display("FAIL %s busy,done,q,r,dbz actual=%b,%b,%h,%h,%b required=all zero",
               name, busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    int target, guard;

    repeat (3) @(negedge clk);
    #1 check_zero("reset_state");
    #2 rst_n = 1'b1;

    // Basic and boundary cases
    issue(64'd100, 64'd7);
    issue('1, 64'd1);
    issue(64'd3, 64'd10);
    issue(64'd5, 64'd0);
    issue(64'd0, 64'd12345);
    issue(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
    issue(64'h0000_0000_FFFF_FFFF, 64'h8000_0000_0000_0000);
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0003);

    // A start in the middle of RUN must be ignored
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    dividend = 64'd9; divisor = 64'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    issue(64'd9, 64'd3);

    // Reset in the middle of RUN abandons the operation
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #3 rst_n = 1'b0;
    sb.delete();
    m_last  = '0;
    free_at = 0;
    #1 check_zero("reset_midrun");
    @(negedge clk);
    #3 rst_n = 1'b1;
    issue(64'd100, 64'd7);

    // Random traffic with start held high
    target = n_accept + NRAND;
    guard  = 0;
    start  = 1'b1;
    while (n_accept < target && guard < NRAND * (LAT + 4)) begin
      a = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if ($urandom_range(0, 99) == 0) b = '0;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    n_cmp++;
    if (n_accept < target) begin
      n_bad++;
      $display("FAIL random_accepts actual=%0d required=%0d", n_accept, target);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
